// File: rtl/riscv_ctrl_fsm.sv
// Multicycle RISC-V control sequencer: fetches and latches an instruction, decodes it,
// and sequences the ALU controls, data-memory access, register writeback and PC update.
module riscv_ctrl_fsm (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic        alu_zero_i,
  output logic [1:0]  alu_op_type_o,
  output logic [2:0]  alu_funct3_o,
  output logic        alu_funct7_bit6_o,
  output logic        alu_srcb_imm_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_we_o,
  output logic        wb_mem_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ifetch_o,
  output logic        pc_we_o,
  output logic        pc_branch_o,
  output logic        illegal_o
);

  localparam int unsigned IW = 32;
  localparam logic [IW-1:0] IR_RESET = 32'h0000_0013;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_BR = 7'b1100011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  localparam logic [1:0] OPT_R  = 2'b00;
  localparam logic [1:0] OPT_I  = 2'b01;
  localparam logic [1:0] OPT_BR = 2'b10;
  localparam logic [1:0] OPT_LS = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_I   = 3'd1,
    C_BR  = 3'd2,
    C_LD  = 3'd3,
    C_ST  = 3'd4,
    C_BAD = 3'd5
  } class_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  class_e        cls;
  logic [2:0]    ir_funct3;
  logic          unused_ir_bits;

  assign ir_funct3      = ir_q[14:12];
  assign rs1_addr_o     = ir_q[19:15];
  assign rs2_addr_o     = ir_q[24:20];
  assign rd_addr_o      = ir_q[11:7];
  assign unused_ir_bits = ^{ir_q[31], ir_q[29:25]};

  // State and instruction register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_FETCH;
      ir_q    <= IR_RESET;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Instruction class from the latched IR; unsupported funct3 encodings fold into C_BAD.
  always_comb begin
    cls = C_BAD;
    case (ir_q[6:0])
      OPC_R:   cls = C_R;
      OPC_I:   cls = C_I;
      OPC_BR:  if (ir_funct3[2:1] == 2'b00) cls = C_BR;
      OPC_LD:  if (ir_funct3 == 3'b010) cls = C_LD;
      OPC_ST:  if (ir_funct3 == 3'b010) cls = C_ST;
      default: cls = C_BAD;
    endcase
  end

  // ALU controls are only driven while the ALU is in use (EXECUTE, and held through MEM).
  always_comb begin
    alu_op_type_o     = OPT_R;
    alu_funct3_o      = 3'b000;
    alu_funct7_bit6_o = 1'b0;
    alu_srcb_imm_o    = 1'b0;
    if (state_q == S_EXECUTE || state_q == S_MEM) begin
      case (cls)
        C_R: begin
          alu_op_type_o     = OPT_R;
          alu_funct3_o      = ir_funct3;
          alu_funct7_bit6_o = ir_q[30];
        end
        C_I: begin
          alu_op_type_o     = OPT_I;
          alu_funct3_o      = ir_funct3;
          alu_funct7_bit6_o = (ir_funct3 == 3'b101) ? ir_q[30] : 1'b0;
          alu_srcb_imm_o    = 1'b1;
        end
        C_BR: begin
          alu_op_type_o = OPT_BR;
          alu_funct3_o  = ir_funct3;
        end
        C_LD, C_ST: begin
          alu_op_type_o  = OPT_LS;
          alu_funct3_o   = 3'b010;
          alu_srcb_imm_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and sequencing outputs.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    reg_we_o    = 1'b0;
    wb_mem_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    ifetch_o    = 1'b0;
    pc_we_o     = 1'b0;
    pc_branch_o = 1'b0;
    illegal_o   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        ifetch_o  = 1'b1;
        if (mem_ready_i) begin
          ir_d    = instr_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (cls == C_BAD) ? S_TRAP : S_EXECUTE;
      end
      S_EXECUTE: begin
        case (cls)
          C_R, C_I:   state_d = S_WB;
          C_LD, C_ST: state_d = S_MEM;
          C_BR: begin
            pc_we_o     = 1'b1;
            pc_branch_o = alu_zero_i;
            state_d     = S_FETCH;
          end
          default:    state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (cls == C_ST);
        if (mem_ready_i) begin
          if (cls == C_LD) begin
            state_d = S_WB;
          end else begin
            pc_we_o = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_we_o = 1'b1;
        wb_mem_o = (cls == C_LD);
        pc_we_o  = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal_o = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule
